dispatch: RTL



---
 rtl/dispatch.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dispatch.sv
// dispatch: in-order dispatch stage of the out-of-order core.
// Holds one fetched instruction in a decode buffer. It decodes the instruction,
// resolves both source operands (register file -> ROB -> same-cycle CDB), and
// issues to the ROB plus either the reservation station or the load/store buffer.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable (low freezes state and suppresses strobes)
//   rollback              misprediction flush
//   if_*                  fetch handshake (if_ready = accept this cycle)
//   reg_rs*/reg_rs*_*     register file read address, value and rename tag
//   rob_rs*_*             ROB operand query (position out, ready/value in)
//   rob_nxt_full/rob_tail ROB allocation status and next entry
//   rs_nxt_full, lsb_nxt_full  downstream allocation status
//   alu_result*, lsb_result*   CDB broadcasts, forwarded in the issue cycle
//   rob_issue/rs_issue/lsb_issue  issue strobes
//   issue_*               shared issue bus
//   rf_rename_*           rename write to the register file

// Resolves one source operand. First match wins: unused/x0, committed
// register, ROB-ready value, ALU CDB, LSB CDB, otherwise wait on the tag.
module dispatch_src #(
  parameter int POS_W = 4
) (
  input  logic             used,
  input  logic [4:0]       areg,
  input  logic [31:0]      reg_val,
  input  logic [POS_W:0]   reg_tag,
  input  logic             rob_ready,
  input  logic [31:0]      rob_val,
  input  logic             alu_result,
  input  logic [31:0]      alu_val,
  input  logic [POS_W-1:0] alu_pos,
  input  logic             lsb_result,
  input  logic [31:0]      lsb_val,
  input  logic [POS_W-1:0] lsb_pos,
  output logic [31:0]      val,
  output logic [POS_W:0]   tag
);
  always_comb begin
    val = '0;
    tag = '0;
    if (!used || areg == 5'd0) begin
      val = '0;
    end else if (!reg_tag[POS_W]) begin
      val = reg_val;
    end else if (rob_ready) begin
      val = rob_val;
    end else if (alu_result && alu_pos == reg_tag[POS_W-1:0]) begin
      val = alu_val;
    end else if (lsb_result && lsb_pos == reg_tag[POS_W-1:0]) begin
      val = lsb_val;
    end else begin
      tag = {1'b1, reg_tag[POS_W-1:0]};
    end
  end
endmodule

module dispatch #(
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_pc,
  input  logic                 if_pred_jump,
  output logic                 if_ready,
  output logic [4:0]           reg_rs1,
  output logic [4:0]           reg_rs2,
  input  logic [31:0]          reg_rs1_val,
  input  logic [31:0]          reg_rs2_val,
  input  logic [ROB_POS_W:0]   reg_rs1_rob_id,
  input  logic [ROB_POS_W:0]   reg_rs2_rob_id,
  output logic [ROB_POS_W-1:0] rob_rs1_pos,
  output logic [ROB_POS_W-1:0] rob_rs2_pos,
  input  logic                 rob_rs1_ready,
  input  logic                 rob_rs2_ready,
  input  logic [31:0]          rob_rs1_val,
  input  logic [31:0]          rob_rs2_val,
  input  logic                 rob_nxt_full,
  input  logic [ROB_POS_W-1:0] rob_tail,
  input  logic                 rs_nxt_full,
  input  logic                 lsb_nxt_full,
  input  logic                 alu_result,
  input  logic [31:0]          alu_result_val,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic                 lsb_result,
  input  logic [31:0]          lsb_result_val,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  output logic                 rob_issue,
  output logic                 rs_issue,
  output logic                 lsb_issue,
  output logic [6:0]           issue_opcode,
  output logic [2:0]           issue_funct3,
  output logic                 issue_funct7,
  output logic [4:0]           issue_rd,
  output logic [31:0]          issue_rs1_val,
  output logic [31:0]          issue_rs2_val,
  output logic [31:0]          issue_imm,
  output logic [31:0]          issue_pc,
  output logic [ROB_POS_W:0]   issue_rs1_rob_id,
  output logic [ROB_POS_W:0]   issue_rs2_rob_id,
  output logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 issue_pred_jump,
  output logic                 issue_rob_ready,
  output logic                 rf_rename_en,
  output logic [4:0]           rf_rename_reg,
  output logic [ROB_POS_W-1:0] rf_rename_rob_pos
);
  localparam int NUM_SRC = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {CLS_ROB, CLS_RS, CLS_LSB} cls_t;

  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_pred;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  cls_t        cls;
  logic        use_rs1, use_rs2, wr_rd, f7;
  logic [31:0] imm;
  logic        can_issue;

  assign opcode = buf_inst[6:0];
  assign funct3 = buf_inst[14:12];

  assign imm_i = {{20{buf_inst[31]}}, buf_inst[31:20]};
  assign imm_s = {{20{buf_inst[31]}}, buf_inst[31:25], buf_inst[11:7]};
  assign imm_b = {{19{buf_inst[31]}}, buf_inst[31], buf_inst[7], buf_inst[30:25],
                  buf_inst[11:8], 1'b0};
  assign imm_u = {buf_inst[31:12], 12'h000};
  assign imm_j = {{11{buf_inst[31]}}, buf_inst[31], buf_inst[19:12], buf_inst[20],
                  buf_inst[30:21], 1'b0};

  always_comb begin
    cls     = CLS_ROB;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    f7      = 1'b0;
    imm     = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin cls = CLS_RS; imm = imm_u; wr_rd = 1'b1; end
      OPC_JAL:    begin cls = CLS_RS; imm = imm_j; wr_rd = 1'b1; end
      OPC_JALR:   begin cls = CLS_RS; imm = imm_i; wr_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin cls = CLS_RS; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin cls = CLS_LSB; imm = imm_i; wr_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin cls = CLS_LSB; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM: begin
        cls = CLS_RS; imm = imm_i; wr_rd = 1'b1; use_rs1 = 1'b1;
        // only SRLI/SRAI carry a funct7 bit; other immediates must not alias SUB
        f7 = (funct3 == 3'b101) & buf_inst[30];
      end
      OPC_OP: begin
        cls = CLS_RS; wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; f7 = buf_inst[30];
      end
      default: ;
    endcase
  end

  assign can_issue = buf_valid & rdy & ~rollback & ~rob_nxt_full
                   & ~((cls == CLS_RS) & rs_nxt_full)
                   & ~((cls == CLS_LSB) & lsb_nxt_full);

  assign if_ready  = rdy & ~rollback & (~buf_valid | can_issue);

  assign rob_issue = can_issue;
  assign rs_issue  = can_issue & (cls == CLS_RS);
  assign lsb_issue = can_issue & (cls == CLS_LSB);

  assign rf_rename_en      = can_issue & wr_rd & (buf_inst[11:7] != 5'd0);
  assign rf_rename_reg     = buf_inst[11:7];
  assign rf_rename_rob_pos = rob_tail;

  assign issue_opcode    = opcode;
  assign issue_funct3    = funct3;
  assign issue_funct7    = f7;
  assign issue_rd        = buf_inst[11:7];
  assign issue_imm       = imm;
  assign issue_pc        = buf_pc;
  assign issue_rob_pos   = rob_tail;
  assign issue_pred_jump = buf_pred;
  assign issue_rob_ready = (cls == CLS_ROB);

  assign reg_rs1     = buf_inst[19:15];
  assign reg_rs2     = buf_inst[24:20];
  assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
  assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];

  // per-source operand resolution
  logic [NUM_SRC-1:0]                src_used, src_rob_ready;
  logic [NUM_SRC-1:0][4:0]           src_areg;
  logic [NUM_SRC-1:0][31:0]          src_reg_val, src_rob_val, src_val;
  logic [NUM_SRC-1:0][ROB_POS_W:0]   src_reg_tag, src_tag;

  assign src_used      = {use_rs2, use_rs1};
  assign src_areg      = {reg_rs2, reg_rs1};
  assign src_reg_val   = {reg_rs2_val, reg_rs1_val};
  assign src_reg_tag   = {reg_rs2_rob_id, reg_rs1_rob_id};
  assign src_rob_ready = {rob_rs2_ready, rob_rs1_ready};
  assign src_rob_val   = {rob_rs2_val, rob_rs1_val};

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      dispatch_src #(.POS_W(ROB_POS_W)) u_src (
        .used      (src_used[g]),
        .areg      (src_areg[g]),
        .reg_val   (src_reg_val[g]),
        .reg_tag   (src_reg_tag[g]),
        .rob_ready (src_rob_ready[g]),
        .rob_val   (src_rob_val[g]),
        .alu_result(alu_result),
        .alu_val   (alu_result_val),
        .alu_pos   (alu_result_rob_pos),
        .lsb_result(lsb_result),
        .lsb_val   (lsb_result_val),
        .lsb_pos   (lsb_result_rob_pos),
        .val       (src_val[g]),
        .tag       (src_tag[g])
      );
    end
  endgenerate

  assign issue_rs1_val    = src_val[0];
  assign issue_rs2_val    = src_val[1];
  assign issue_rs1_rob_id = src_tag[0];
  assign issue_rs2_rob_id = src_tag[1];

  // accept has priority over the clear: when the buffer drains and refills in
  // the same cycle it simply stays valid with the new instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (rdy) begin
      if (rollback)                  buf_valid <= 1'b0;
      else if (if_valid && if_ready) buf_valid <= 1'b1;
      else if (can_issue)            buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (if_valid && if_ready) begin
      buf_inst <= if_inst;
      buf_pc   <= if_pc;
      buf_pred <= if_pred_jump;
    end
  end
endmodule
